// File: rtl/fifo_wr_arbiter.sv
// Write-side burst arbiter for the async FIFO: grants one of two producers a
// whole burst only when the FIFO has room for it, with round-robin fairness.
module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 10,
  parameter int BLEN_W   = 8
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [1:0]          req,
  input  logic [BLEN_W-1:0]   blen0,
  input  logic [BLEN_W-1:0]   blen1,
  input  logic [1:0]          vld,
  input  logic [DSIZE-1:0]    din0,
  input  logic [DSIZE-1:0]    din1,
  input  logic [ADDRSIZE:0]   wspace,
  input  logic                wfull,
  output logic [1:0]          gnt,
  output logic                wen,
  output logic [DSIZE-1:0]    wdata,
  output logic                done,
  output logic                abort
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [BLEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;

  logic [ADDRSIZE:0]   blen0_ext, blen1_ext;
  logic [1:0]          elig;

  // A requester is eligible only if the whole burst fits in the free space.
  always_comb begin
    blen0_ext = (ADDRSIZE+1)'(blen0);
    blen1_ext = (ADDRSIZE+1)'(blen1);
    elig[0]   = req[0] && (blen0 != '0) && (blen0_ext <= wspace);
    elig[1]   = req[1] && (blen1 != '0) && (blen1_ext <= wspace);
  end

  always_comb begin
    wen   = (state_q == BURST) && vld[sel_q] && !wfull;
    wdata = '0;
    if (state_q == BURST) begin
      wdata = sel_q ? din1 : din0;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          sel_d   = (elig == 2'b11) ? rr_ptr_q : elig[1];
          cnt_d   = sel_d ? blen1 : blen0;
          gnt_d   = sel_d ? 2'b10 : 2'b01;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wen) begin
          cnt_d = cnt_q - 1'b1;
        end
        // A final beat completes the burst even if req drops in that cycle.
        if (wen && (cnt_q == BLEN_W'(1))) begin
          done_d = 1'b1;
        end else if (!req[sel_q]) begin
          abort_d = 1'b1;
        end
        if (done_d || abort_d) begin
          state_d  = GAP;
          gnt_d    = '0;
          rr_ptr_d = ~sel_q;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed burst scenarios plus random traffic,
// every cycle compared against a words-remaining transaction model.
module tb_fifo_wr_arbiter;
  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 10;
  localparam int BLEN_W   = 8;

  logic                wclk = 1'b0;
  logic                wrst;
  logic [1:0]          req;
  logic [BLEN_W-1:0]   blen0, blen1;
  logic [1:0]          vld;
  logic [DSIZE-1:0]    din0, din1;
  logic [ADDRSIZE:0]   wspace;
  logic                wfull;
  logic [1:0]          gnt;
  logic                wen;
  logic [DSIZE-1:0]    wdata;
  logic                done, abort;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE), .BLEN_W(BLEN_W)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .blen0(blen0), .blen1(blen1),
    .vld(vld), .din0(din0), .din1(din1), .wspace(wspace), .wfull(wfull),
    .gnt(gnt), .wen(wen), .wdata(wdata), .done(done), .abort(abort)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Transaction model: owner of the write port (-1 none), words still owed,
  // one idle cycle after each burst, and whose turn it is on a tie.
  int m_owner, m_left, m_rr;
  bit m_gap, m_done, m_abort;

  int         n_wen, n_done, n_abort;
  logic [1:0] grants[$];
  logic [1:0] prev_gnt;

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_rr = 0;
    m_gap = 0; m_done = 0; m_abort = 0;
  endtask

  task automatic clear_obs();
    n_wen = 0; n_done = 0; n_abort = 0;
    grants.delete();
    prev_gnt = 2'b00;
  endtask

  function automatic logic [1:0] grant_at(input int k);
    return (grants.size() > k) ? grants[k] : 2'bxx;
  endfunction

  // Check the current cycle at the falling edge, advance the model across the
  // next rising edge, then return 1 time unit after it with fresh data words.
  task automatic step();
    logic [1:0]       e_gnt;
    bit               e_wen, e0, e1, nd, na;
    logic [DSIZE-1:0] e_wdata;
    int               w;
    @(negedge wclk);
    if (wrst) begin
      model_reset();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_wen", 32'(wen), 0);
      check("rst_wdata", 32'(wdata), 0);
      check("rst_done", 32'(done), 0);
      check("rst_abort", 32'(abort), 0);
      prev_gnt = 2'b00;
    end else begin
      e_gnt = 2'b00; e_wen = 0; e_wdata = '0;
      if (m_owner >= 0) begin
        e_gnt   = (m_owner == 1) ? 2'b10 : 2'b01;
        e_wen   = vld[m_owner] && !wfull;
        e_wdata = (m_owner == 1) ? din1 : din0;
      end
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("wen", 32'(wen), 32'(e_wen));
      check("wdata", 32'(wdata), 32'(e_wdata));
      check("done", 32'(done), 32'(m_done));
      check("abort", 32'(abort), 32'(m_abort));
      check("done_abort_excl", 32'(done && abort), 0);
      if (wen === 1'b1) n_wen++;
      if (done === 1'b1) n_done++;
      if (abort === 1'b1) n_abort++;
      if (gnt != 2'b00 && prev_gnt == 2'b00) grants.push_back(gnt);
      prev_gnt = gnt;
      nd = 0; na = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_owner < 0) begin
        e0 = req[0] && blen0 != 0 && int'(blen0) <= int'(wspace);
        e1 = req[1] && blen1 != 0 && int'(blen1) <= int'(wspace);
        w  = (e0 && e1) ? m_rr : e0 ? 0 : e1 ? 1 : -1;
        if (w >= 0) begin
          m_owner = w;
          m_left  = (w == 1) ? int'(blen1) : int'(blen0);
        end
      end else begin
        if (e_wen) m_left--;
        if (e_wen && m_left == 0) nd = 1;
        else if (!req[m_owner]) na = 1;
        if (nd || na) begin
          m_rr = 1 - m_owner; m_owner = -1; m_gap = 1;
        end
      end
      m_done = nd; m_abort = na;
    end
    @(posedge wclk);
    #1;
    din0 = DSIZE'($urandom);
    din1 = DSIZE'($urandom);
  endtask

  task automatic run_until(input string tag, input int target, input int budget);
    int k = 0;
    while ((n_done + n_abort) < target && k < budget) begin
      step();
      k++;
    end
    check({tag, "_in_time"}, 32'((n_done + n_abort) >= target), 1);
  endtask

  task automatic do_reset();
    wrst = 1'b1; req = 2'b00; vld = 2'b00; wfull = 1'b0;
    step();
    step();
    wrst = 1'b0;
    clear_obs();
  endtask

  typedef struct { bit v; bit f; } beat_t;
  beat_t t4[9];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    wrst = 1'b1; req = '0; blen0 = '0; blen1 = '0; vld = '0;
    din0 = '0; din1 = '0; wspace = 11'd1024; wfull = 1'b0;
    model_reset();
    clear_obs();

    // 1: single burst from requester 0
    do_reset();
    req = 2'b01; blen0 = 8'd4; vld = 2'b01; wspace = 11'd1024;
    step();
    check("t1_gnt_latency", 32'(gnt), 32'(2'b01));
    run_until("t1", 1, 20);
    req = 2'b00;
    step(); step();
    check("t1_words", 32'(n_wen), 4);
    check("t1_done_cnt", 32'(n_done), 1);
    check("t1_gnt_idle", 32'(gnt), 0);

    // 2: round-robin between two equal bursts
    do_reset();
    req = 2'b11; blen0 = 8'd2; blen1 = 8'd2; vld = 2'b11;
    run_until("t2", 3, 40);
    req = 2'b00;
    step(); step();
    check("t2_words", 32'(n_wen), 6);
    check("t2_done_cnt", 32'(n_done), 3);
    check("t2_order0", 32'(grant_at(0)), 32'(2'b01));
    check("t2_order1", 32'(grant_at(1)), 32'(2'b10));
    check("t2_order2", 32'(grant_at(2)), 32'(2'b01));

    // 3: oversize burst waits while the small one goes through
    do_reset();
    req = 2'b11; blen0 = 8'd200; blen1 = 8'd8; wspace = 11'd100; vld = 2'b11;
    run_until("t3a", 1, 30);
    req = 2'b01;
    check("t3_first_gnt", 32'(grant_at(0)), 32'(2'b10));
    check("t3_small_words", 32'(n_wen), 8);
    for (int i = 0; i < 6; i++) step();
    check("t3_big_waits", 32'(gnt), 0);
    wspace = 11'd600;
    step();
    check("t3_big_gnt", 32'(gnt), 32'(2'b01));
    run_until("t3b", 2, 260);
    req = 2'b00;
    step(); step();
    check("t3_total_words", 32'(n_wen), 208);

    // 4: stalls on vld low and wfull hold the beat counter
    t4 = '{'{1, 0}, '{1, 0}, '{0, 0}, '{0, 0}, '{1, 0}, '{1, 1}, '{1, 0}, '{1, 0}, '{1, 0}};
    do_reset();
    req = 2'b10; blen1 = 8'd5; wspace = 11'd1024;
    foreach (t4[i]) begin
      vld = {t4[i].v, 1'b0};
      wfull = t4[i].f;
      step();
    end
    req = 2'b00; vld = 2'b00; wfull = 1'b0;
    step(); step(); step();
    check("t4_words", 32'(n_wen), 5);
    check("t4_done_cnt", 32'(n_done), 1);

    // 5: requester 0 abandons its burst; pending requester 1 follows
    do_reset();
    req = 2'b01; blen0 = 8'd6; vld = 2'b01;
    k = 0;
    while (n_wen < 3 && k < 20) begin step(); k++; end
    check("t5_three_words", 32'(n_wen), 3);
    req = 2'b10; vld = 2'b10; blen1 = 8'd3;
    run_until("t5", 2, 30);
    req = 2'b00;
    step(); step();
    check("t5_abort_cnt", 32'(n_abort), 1);
    check("t5_done_cnt", 32'(n_done), 1);
    check("t5_words", 32'(n_wen), 6);
    check("t5_next_gnt", 32'(grant_at(1)), 32'(2'b10));

    // 6: asynchronous reset in the middle of requester 1's burst
    do_reset();
    req = 2'b11; blen0 = 8'd4; blen1 = 8'd4; vld = 2'b11;
    run_until("t6", 1, 20);
    k = 0;
    while (n_wen < 6 && k < 20) begin step(); k++; end
    check("t6_mid_owner", 32'(gnt), 32'(2'b10));
    #2 wrst = 1'b1;
    #1;
    check("t6_async_gnt", 32'(gnt), 0);
    check("t6_async_wen", 32'(wen), 0);
    check("t6_async_done", 32'(done), 0);
    check("t6_async_abort", 32'(abort), 0);
    step();
    wrst = 1'b0;
    clear_obs();
    step(); step(); step();
    check("t6_rr_reset", 32'(grant_at(0)), 32'(2'b01));

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      if ($urandom_range(0, 7) == 0)
        blen0 = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0)
        blen1 = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) wspace = 11'($urandom_range(0, 1024));
      vld   = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      wfull = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
